hiscore_ram_arbiter: RTL

HISCORE_RAM_ARBITER -- requirements
Module: hiscore_ram_arbiter

---
 rtl/hiscore_ram_arbiter.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/hiscore_ram_arbiter.sv
// ---------------------------------------------------------------------------
// hiscore_ram_arbiter
//
// Purpose:
//   Arbitrates one shared work RAM between the CPU and the hiscore engine.
//   The CPU owns the RAM by default. When the hiscore engine signals intent
//   (read or write), the arbiter asks the CPU to pause, waits for its
//   acknowledge and then hands the RAM over. When intent drops, the arbiter
//   waits out the RAM read latency before returning the RAM to the CPU, so
//   in-flight hiscore reads still land in hs_data_out.
//
// Ports:
//   clk_sys         system clock, all state changes on its rising edge
//   reset           asynchronous active-high reset (deassert synchronised)
//   cpu_addr/dout/we  CPU side of the RAM bus; cpu_din returns RAM data
//   cpu_pause_req   high whenever the CPU does not own the RAM
//   cpu_paused      CPU acknowledge that it is halted at a safe boundary
//   hs_address/data_in/write  hiscore side of the RAM bus
//   hs_access_read/write      hiscore intent to use the RAM
//   hs_data_out     hiscore read data, captured RD_LAT cycles after each
//                   hiscore-owned cycle and held otherwise
//   hs_grant        high while the hiscore engine owns the RAM
//   ram_addr/wdata/we/rdata   shared RAM port
//
// Parameters:
//   RD_LAT  RAM read latency in clk_sys cycles (1..3)
//   AW      address bus width
// ---------------------------------------------------------------------------
module hiscore_ram_arbiter #(
    parameter int RD_LAT = 1,
    parameter int AW     = 16
) (
    input  logic          clk_sys,
    input  logic          reset,

    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_dout,
    input  logic          cpu_we,
    output logic [7:0]    cpu_din,
    output logic          cpu_pause_req,
    input  logic          cpu_paused,

    input  logic [AW-1:0] hs_address,
    input  logic [7:0]    hs_data_in,
    input  logic          hs_write,
    input  logic          hs_access_read,
    input  logic          hs_access_write,
    output logic [7:0]    hs_data_out,
    output logic          hs_grant,

    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    output logic          ram_we,
    input  logic [7:0]    ram_rdata
);

    typedef enum logic [1:0] {
        ST_CPU     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HS      = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Last cycle index of RELEASE: RELEASE lasts exactly RD_LAT cycles.
    localparam logic [1:0] REL_LAST = 2'(RD_LAT - 1);

    // -----------------------------------------------------------------------
    // Reset synchroniser: assertion is immediate, deassertion takes two
    // clk_sys edges so no state flop sees reset release near a clock edge.
    // -----------------------------------------------------------------------
    logic [1:0] rst_sync_reg;
    logic       rst_int;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rst_sync_reg <= 2'b11;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b0};
        end
    end

    assign rst_int = rst_sync_reg[1];

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t              state_reg, state_next;
    logic [1:0]          rel_cnt_reg, rel_cnt_next;
    logic [AW-1:0]       last_cpu_addr_reg;
    logic [AW-1:0]       last_hs_addr_reg;
    logic [RD_LAT-1:0]   vld_reg, vld_next;
    logic [7:0]          hs_data_out_reg;
    logic                intent;

    assign intent = hs_access_read | hs_access_write;

    always_ff @(posedge clk_sys or posedge rst_int) begin
        if (rst_int) begin
            state_reg   <= ST_CPU;
            rel_cnt_reg <= 2'd0;
        end else begin
            state_reg   <= state_next;
            rel_cnt_reg <= rel_cnt_next;
        end
    end

    // Addresses held on the bus while nobody owns the RAM, so the RAM sees
    // a stable address across the handover.
    always_ff @(posedge clk_sys or posedge rst_int) begin
        if (rst_int) begin
            last_cpu_addr_reg <= '0;
            last_hs_addr_reg  <= '0;
        end else begin
            if (state_reg == ST_CPU) begin
                last_cpu_addr_reg <= cpu_addr;
            end
            if (state_reg == ST_HS) begin
                last_hs_addr_reg <= hs_address;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read-valid pipeline: a token enters for every hiscore-owned cycle and
    // emerges RD_LAT cycles later, exactly when that cycle's read data is on
    // ram_rdata.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_vld
            if (gi == 0) begin : g_head
                assign vld_next[gi] = (state_reg == ST_HS);
            end else begin : g_tail
                assign vld_next[gi] = vld_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk_sys or posedge rst_int) begin
        if (rst_int) begin
            vld_reg         <= '0;
            hs_data_out_reg <= 8'h00;
        end else begin
            vld_reg <= vld_next;
            if (vld_reg[RD_LAT-1]) begin
                hs_data_out_reg <= ram_rdata;
            end
        end
    end

    assign hs_data_out = hs_data_out_reg;
    assign cpu_din     = ram_rdata;

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        rel_cnt_next  = rel_cnt_reg;
        cpu_pause_req = 1'b1;
        hs_grant      = 1'b0;
        ram_addr      = cpu_addr;
        ram_wdata     = cpu_dout;
        ram_we        = cpu_we;

        case (state_reg)
            ST_CPU: begin
                cpu_pause_req = 1'b0;
                if (intent) begin
                    state_next = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                // Nobody writes while the CPU finishes its current access.
                ram_addr  = last_cpu_addr_reg;
                ram_wdata = 8'h00;
                ram_we    = 1'b0;
                // Intent withdrawn before the CPU acknowledged: abort.
                if (!intent) begin
                    state_next = ST_CPU;
                end else if (cpu_paused) begin
                    state_next = ST_HS;
                end
            end

            ST_HS: begin
                hs_grant  = 1'b1;
                ram_addr  = hs_address;
                ram_wdata = hs_data_in;
                ram_we    = hs_write & hs_access_write;
                // Losing cpu_paused here is ignored: the request stays high
                // and the hiscore engine keeps the RAM until it lets go.
                if (!intent) begin
                    state_next   = ST_RELEASE;
                    rel_cnt_next = 2'd0;
                end
            end

            ST_RELEASE: begin
                ram_addr  = last_hs_addr_reg;
                ram_wdata = 8'h00;
                ram_we    = 1'b0;
                // Always pass through CPU, even if intent is back, so the
                // CPU gets at least one cycle between hiscore sessions.
                if (rel_cnt_reg == REL_LAST) begin
                    state_next = ST_CPU;
                end else begin
                    rel_cnt_next = rel_cnt_reg + 2'd1;
                end
            end

            default: begin
                state_next = ST_CPU;
            end
        endcase
    end

endmodule
